param_link: RTL
===============

PARAM_LINK -- requirements
Module: param_link

Interface
REQ-001 Parameter DATA_W, default 8: width of each transferred word.
REQ-002 Parameter MAX_LEN, default 16: maximum words per burst.
REQ-003 Parameter ACK_WAIT, default 0: extra cycles the slave waits before raising ack.
REQ-004 Port list SHALL be:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- burst_len  input  LEN_W=$clog2(MAX_LEN+1)  word count for the burst.
- base_data  input  DATA_W  value of the first word.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse at burst end.
- word_count  output  LEN_W  words acknowledged in the current or last burst.
- last_word  output  DATA_W  last word captured by the slave.
- checksum  output  DATA_W  present only with LINK_CHECKSUM_EN.

Function
REQ-005 Master SHALL send word i = (base_data + i) mod 2^DATA_W, i = 0..L-1, over an internal 4-phase req/ack handshake.
REQ-006 Effective length L SHALL be min(burst_len, MAX_LEN), latched when start is accepted.
REQ-007 Master FSM states SHALL be M_IDLE, M_REQ, M_ACKLOW, M_DONE.
- M_IDLE + start: go to M_REQ, or to M_DONE if L = 0.
- M_REQ: req = 1, data held stable; on ack = 1, drop req, increment index, go to M_ACKLOW.
- M_ACKLOW: on ack = 0, go to M_DONE if index = L, else M_REQ.
- M_DONE: done = 1 for one cycle, then M_IDLE.
REQ-008 Slave FSM states SHALL be S_IDLE, S_WAIT, S_ACK.
- S_IDLE + req = 1: capture data into last_word, go to S_WAIT.
- S_WAIT: count ACK_WAIT cycles, then enter S_ACK; with ACK_WAIT = 0, go straight to S_ACK.
- S_ACK: ack = 1 until req = 0, then S_IDLE.
REQ-009 req and ack SHALL be registered.
- With ACK_WAIT = 0, word k (0-based) asserts req 4k+1 cycles after the start edge, and each word takes exactly 4 cycles.
- In general each word takes 4 + ACK_WAIT cycles.
REQ-010 word_count SHALL increment on each ack-high capture by the master; it clears to 0 when a new start is accepted.
REQ-011 start asserted while busy SHALL be ignored, with no effect on the running burst.
REQ-012 With L = 0:
- busy SHALL be high for 1 cycle, coincident with done;
- req never asserts;
- last_word and word_count = 0 are unchanged apart from the word_count clear.
REQ-013 Word values and checksum SHALL wrap modulo 2^DATA_W without saturation.
REQ-014 Outputs SHALL remain valid between bursts until the next accepted start.

Reset
REQ-015 On rst = 0, asynchronously:
- both FSMs go to IDLE;
- req, ack, busy and done become 0;
- word_count, last_word and checksum become 0.
REQ-016 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block accepts a new start on the first clk edge.

Configuration
REQ-017 With macro LINK_CHECKSUM_EN defined:
- the slave keeps checksum = sum of captured words mod 2^DATA_W;
- checksum clears on accepted start;
- the checksum port exists.
REQ-018 Without LINK_CHECKSUM_EN, neither the checksum port nor its logic SHALL exist, and all other behaviour is identical.

Structure
REQ-019 A shared package param_link_pkg SHALL hold:
- the master and slave state enum typedefs;
- the LEN_W computation function.
REQ-020 The slave SHALL be a sub-module, param_link_slave (S FSM, ACK_WAIT counter, last_word, checksum); the master FSM sits in param_link.

Verification
REQ-021 DATA_W = 8, ACK_WAIT = 0, base_data = 0x10, burst_len = 4 -> words 0x10..0x13; done 17 cycles after start; word_count = 4; last_word = 0x13; checksum = 0x46.
REQ-022 base_data = 0xFE, burst_len = 3 -> words 0xFE, 0xFF, 0x00; last_word = 0x00; checksum = 0xFD.
REQ-023 burst_len = 0 -> done one cycle after start; req never high; word_count = 0.
REQ-024 MAX_LEN = 16, burst_len = 31 -> exactly 16 words; word_count = 16; start pulsed mid-burst is ignored.
REQ-025 ACK_WAIT = 2, burst_len = 2 -> 6 cycles per word; done 13 cycles after start.
REQ-026 rst pulled low during word 2 of 5 -> req/ack/busy = 0 immediately, no done; a new burst_len = 1 start afterwards completes normally.

Source files
------------

// File: rtl/param_link_pkg.sv
// Shared types and width helpers for the param_link block.
// The optional checksum (LINK_CHECKSUM_EN) needs nothing from this package.
package param_link_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_REQ,
        M_ACKLOW,
        M_DONE
    } m_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } s_state_t;

    // Width able to hold 0..max_len inclusive.
    function automatic int calc_len_w(input int max_len);
        return (max_len < 1) ? 1 : $clog2(max_len + 1);
    endfunction

    // Width of the slave's ack-delay counter (counts 0..ack_wait-1).
    function automatic int calc_wait_w(input int ack_wait);
        return (ack_wait < 2) ? 1 : $clog2(ack_wait);
    endfunction

endpackage

// File: rtl/param_link_if.sv
// Internal 4-phase req/ack link between the burst master and the slave.
// Unaffected by LINK_CHECKSUM_EN.
interface param_link_if #(
    parameter int DATA_W = 8
);
    logic              req;
    logic              ack;
    logic [DATA_W-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/param_link_slave.sv
// Receiving end of the link: delays ack by ACK_WAIT cycles and captures words.
// With LINK_CHECKSUM_EN defined it also keeps a running modular sum of captured words.
module param_link_slave
    import param_link_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACK_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    param_link_if.slave       hs,
    output logic [DATA_W-1:0] last_word
`ifdef LINK_CHECKSUM_EN
    ,
    input  logic              clr,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int                WAIT_W    = calc_wait_w(ACK_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ACK_WAIT > 0) ? ACK_WAIT - 1 : 0);

    s_state_t          s_state_reg, s_state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              ack_reg;
    logic [DATA_W-1:0] last_word_reg;
    logic              capture;

    // ack is a registered decode of the next state so it rises on the same
    // edge the FSM enters S_ACK.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_state_reg  <= S_IDLE;
            wait_cnt_reg <= '0;
            ack_reg      <= 1'b0;
        end else begin
            s_state_reg  <= s_state_next;
            wait_cnt_reg <= wait_cnt_next;
            ack_reg      <= (s_state_next == S_ACK);
        end
    end

    always_comb begin
        s_state_next  = s_state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (s_state_reg)
            S_IDLE: begin
                if (hs.req) begin
                    wait_cnt_next = '0;
                    s_state_next  = (ACK_WAIT == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    s_state_next = S_ACK;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_ACK: begin
                if (!hs.req) begin
                    s_state_next = S_IDLE;
                end
            end
            default: s_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        capture = (s_state_reg == S_IDLE) && hs.req;
    end

    assign hs.ack    = ack_reg;
    assign last_word = last_word_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_word_reg <= '0;
        end else if (capture) begin
            last_word_reg <= hs.data;
        end
    end

`ifdef LINK_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg;

    // clr and capture never coincide: the slave is idle whenever a start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_reg <= '0;
        end else if (clr) begin
            checksum_reg <= '0;
        end else if (capture) begin
            checksum_reg <= checksum_reg + hs.data;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: rtl/param_link.sv
// Burst master: sends base_data, base_data+1, ... over a 4-phase link to param_link_slave.
// Define LINK_CHECKSUM_EN to add the checksum output.
module param_link
    import param_link_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  MAX_LEN  = 16,
    parameter int  ACK_WAIT = 0,
    localparam int LEN_W    = calc_len_w(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] base_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_count,
    output logic [DATA_W-1:0] last_word
`ifdef LINK_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    m_state_t          m_state_reg, m_state_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  word_count_reg, word_count_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              req_reg;
    logic [LEN_W-1:0]  start_len;

    param_link_if #(.DATA_W(DATA_W)) hs ();

    assign start_len = (burst_len > MAX_LEN_V) ? MAX_LEN_V : burst_len;

    // word_count doubles as the word index; req follows the next state so the
    // next word goes out on the same edge the master sees ack fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state_reg    <= M_IDLE;
            len_reg        <= '0;
            word_count_reg <= '0;
            data_reg       <= '0;
            req_reg        <= 1'b0;
        end else begin
            m_state_reg    <= m_state_next;
            len_reg        <= len_next;
            word_count_reg <= word_count_next;
            data_reg       <= data_next;
            req_reg        <= (m_state_next == M_REQ);
        end
    end

    always_comb begin
        m_state_next    = m_state_reg;
        len_next        = len_reg;
        word_count_next = word_count_reg;
        data_next       = data_reg;
        case (m_state_reg)
            M_IDLE: begin
                if (start) begin
                    len_next        = start_len;
                    word_count_next = '0;
                    data_next       = base_data;
                    m_state_next    = (start_len == '0) ? M_DONE : M_REQ;
                end
            end
            M_REQ: begin
                if (hs.ack) begin
                    word_count_next = word_count_reg + 1'b1;
                    data_next       = data_reg + 1'b1;
                    m_state_next    = M_ACKLOW;
                end
            end
            M_ACKLOW: begin
                if (!hs.ack) begin
                    m_state_next = (word_count_reg == len_reg) ? M_DONE : M_REQ;
                end
            end
            M_DONE:  m_state_next = M_IDLE;
            default: m_state_next = M_IDLE;
        endcase
    end

    always_comb begin
        busy = (m_state_reg != M_IDLE);
        done = (m_state_reg == M_DONE);
    end

    assign hs.req     = req_reg;
    assign hs.data    = data_reg;
    assign word_count = word_count_reg;

`ifdef LINK_CHECKSUM_EN
    logic accept;
    assign accept = (m_state_reg == M_IDLE) && start;
`endif

    param_link_slave #(
        .DATA_W   (DATA_W),
        .ACK_WAIT (ACK_WAIT)
    ) u_slave (
        .clk       (clk),
        .rst       (rst),
        .hs        (hs),
        .last_word (last_word)
`ifdef LINK_CHECKSUM_EN
        ,
        .clr       (accept),
        .checksum  (checksum)
`endif
    );

endmodule
